// File: rtl/projection_matrix_ctrl_if.sv
// rtl/projection_matrix_ctrl_if.sv - request, operand and result bundle of projection_matrix_ctrl
interface projection_matrix_ctrl_if #(
  parameter int WI = 8,
  parameter int WF = 8
);
  localparam int W = WI + WF;

  logic                  start;
  logic [W-1:0]          inv_tan;
  logic [W-1:0]          aspect_ratio;
  logic [W-1:0]          z_near;
  logic [W-1:0]          z_far;
  logic                  busy;
  logic                  done;
  logic [15:0][W-1:0]    projection_matrix;
  logic                  ovf;
  logic                  div_zero;

  modport master (
    output start, inv_tan, aspect_ratio, z_near, z_far,
    input  busy, done, projection_matrix, ovf, div_zero
  );

  modport slave (
    input  start, inv_tan, aspect_ratio, z_near, z_far,
    output busy, done, projection_matrix, ovf, div_zero
  );
endinterface

// File: rtl/projection_matrix_ctrl.sv
// rtl/projection_matrix_ctrl.sv - serial perspective projection matrix generator (shared divider, fixed 52-cycle schedule)
module projection_matrix_ctrl #(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  projection_matrix_ctrl_if.slave   bus_io
);
  localparam int W  = WI + WF;
  localparam int NQ = W + WF + 1;
  localparam int CW = $clog2(NQ);

  localparam logic [CW-1:0]       LAST    = CW'(NQ - 1);
  localparam logic [W-1:0]        POS_SAT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        NEG_SAT = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        ONE     = W'(1 << WF);
  localparam logic [2*W:0]        HALF    = (2*W+1)'(1 << (WF - 1));
  localparam logic signed [2*W:0] SMAX    = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] SMIN    = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV_K, S_DIV_A, S_MUL, S_DONE} state_t;

  // Saturating helpers return {overflow, value}.
  function automatic logic [W:0] sat_w(input logic signed [2*W:0] x);
    if (x > SMAX) return {1'b1, POS_SAT};
    if (x < SMIN) return {1'b1, NEG_SAT};
    return {1'b0, x[W-1:0]};
  endfunction

  function automatic logic [W:0] mul_rnd(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    logic [2*W:0]          mag;
    logic signed [2*W:0]   r;
    p   = a * b;
    mag = {1'b0, (p[2*W-1] ? -p : p)};
    mag = (mag + HALF) >> WF;
    r   = $signed(mag);
    return sat_w(p[2*W-1] ? -r : r);
  endfunction

  function automatic logic [W-1:0] mag_w(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       inv_tan_q, aspect_q, z_near_q, z_far_q;
  logic [W-1:0]       sum_q, prod_q, k_q, tda_q;
  logic [W-1:0]       rem_q, dsor_q;
  logic [NQ-1:0]      dvd_q, quo_q;
  logic               qneg_q, dzero_q, dvd_neg_q;
  logic               ovf_acc_q, dz_acc_q;
  logic               busy_q, done_q, ovf_q, div_zero_q;
  logic [15:0][W-1:0] mat_q;

  logic signed [W+1:0] zn_x, zf_x, dist_x, sum_x;
  logic [W:0]          dist_s, sum_s, prod_s;
  logic [W:0]          rem_sh;
  logic                ge;
  logic [W-1:0]        rem_d;
  logic [NQ-1:0]       quo_d, qmag;
  logic [W-1:0]        qval;
  logic                q_ovf, q_dz;
  logic                ld_en;
  logic [W-1:0]        ld_dvd, ld_dsor;
  logic [W:0]          m10, m11a, m11s;
  logic signed [2*W:0] m11_x;
  logic [15:0][W-1:0]  mat_d;

  // Depth terms are formed two bits wider so -z and the differences never wrap before saturation.
  always_comb begin
    zn_x   = {{2{z_near_q[W-1]}}, z_near_q};
    zf_x   = {{2{z_far_q[W-1]}}, z_far_q};
    dist_x = zf_x - zn_x;
    sum_x  = -zn_x - zf_x;
    dist_s = sat_w({{(W-1){dist_x[W+1]}}, dist_x});
    sum_s  = sat_w({{(W-1){sum_x[W+1]}}, sum_x});
    prod_s = mul_rnd(z_far_q, z_near_q);
  end

  always_comb begin
    rem_sh = {rem_q, dvd_q[NQ-1]};
    ge     = rem_sh >= {1'b0, dsor_q};
    rem_d  = ge ? W'(rem_sh - {1'b0, dsor_q}) : rem_sh[W-1:0];
    quo_d  = {quo_q[NQ-2:0], ge};
    qmag   = {1'b0, quo_d[NQ-1:1]} + NQ'(quo_d[0]);
    q_ovf  = 1'b0;
    q_dz   = 1'b0;
    if (dzero_q) begin
      q_dz = 1'b1;
      qval = dvd_neg_q ? NEG_SAT : POS_SAT;
    end else if (qmag > NQ'(POS_SAT)) begin
      q_ovf = 1'b1;
      qval  = qneg_q ? NEG_SAT : POS_SAT;
    end else begin
      qval = qneg_q ? -qmag[W-1:0] : qmag[W-1:0];
    end
  end

  // The same divider runs 1/dist first, then is reloaded with inv_tan/aspect on the last DIV_K step.
  always_comb begin
    ld_en   = (state_q == S_LOAD) || (state_q == S_DIV_K && cnt_q == LAST);
    ld_dvd  = (state_q == S_LOAD) ? ONE : inv_tan_q;
    ld_dsor = (state_q == S_LOAD) ? dist_s[W-1:0] : aspect_q;
  end

  always_comb begin
    m10   = mul_rnd(sum_q, k_q);
    m11a  = mul_rnd(prod_q, k_q);
    m11_x = $signed({{(W+1){m11a[W-1]}}, m11a[W-1:0]}) <<< 1;
    m11s  = sat_w(m11_x);
    mat_d     = '0;
    mat_d[0]  = tda_q;
    mat_d[5]  = inv_tan_q;
    mat_d[10] = m10[W-1:0];
    mat_d[11] = m11s[W-1:0];
    mat_d[14] = ONE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      inv_tan_q  <= '0;
      aspect_q   <= '0;
      z_near_q   <= '0;
      z_far_q    <= '0;
      sum_q      <= '0;
      prod_q     <= '0;
      k_q        <= '0;
      tda_q      <= '0;
      rem_q      <= '0;
      dsor_q     <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      qneg_q     <= 1'b0;
      dzero_q    <= 1'b0;
      dvd_neg_q  <= 1'b0;
      ovf_acc_q  <= 1'b0;
      dz_acc_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      div_zero_q <= 1'b0;
      mat_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.start) begin
            inv_tan_q <= bus_io.inv_tan;
            aspect_q  <= bus_io.aspect_ratio;
            z_near_q  <= bus_io.z_near;
            z_far_q   <= bus_io.z_far;
            ovf_acc_q <= 1'b0;
            dz_acc_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          sum_q     <= sum_s[W-1:0];
          prod_q    <= prod_s[W-1:0];
          ovf_acc_q <= ovf_acc_q | dist_s[W] | sum_s[W] | prod_s[W];
          state_q   <= S_DIV_K;
        end
        S_DIV_K: begin
          if (cnt_q == LAST) begin
            k_q       <= qval;
            ovf_acc_q <= ovf_acc_q | q_ovf;
            dz_acc_q  <= dz_acc_q | q_dz;
            state_q   <= S_DIV_A;
          end
        end
        S_DIV_A: begin
          if (cnt_q == LAST) begin
            tda_q     <= qval;
            ovf_acc_q <= ovf_acc_q | q_ovf;
            dz_acc_q  <= dz_acc_q | q_dz;
            state_q   <= S_MUL;
          end
        end
        S_MUL: begin
          mat_q      <= mat_d;
          ovf_q      <= ovf_acc_q | m10[W] | m11a[W] | m11s[W];
          div_zero_q <= dz_acc_q;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (ld_en) begin
        dvd_q     <= {mag_w(ld_dvd), (WF+1)'(0)};
        dsor_q    <= mag_w(ld_dsor);
        qneg_q    <= ld_dvd[W-1] ^ ld_dsor[W-1];
        dzero_q   <= (ld_dsor == '0);
        dvd_neg_q <= ld_dvd[W-1];
        rem_q     <= '0;
        quo_q     <= '0;
        cnt_q     <= '0;
      end else if (state_q == S_DIV_K || state_q == S_DIV_A) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvd_q <= dvd_q << 1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus_io.busy              = busy_q;
  assign bus_io.done              = done_q;
  assign bus_io.projection_matrix = mat_q;
  assign bus_io.ovf               = ovf_q;
  assign bus_io.div_zero          = div_zero_q;
endmodule

// File: tb/tb_projection_matrix_ctrl.sv
// tb/tb_projection_matrix_ctrl.sv - directed vector bench for projection_matrix_ctrl
module tb_projection_matrix_ctrl;
  localparam int WI = 8;
  localparam int WF = 8;

  logic clk = 1'b0;
  logic rstn;

  projection_matrix_ctrl_if #(.WI(WI), .WF(WF)) bus ();

  projection_matrix_ctrl #(.WI(WI), .WF(WF)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inv_tan;
    logic [15:0] aspect;
    logic [15:0] z_near;
    logic [15:0] z_far;
    logic [15:0] e0;
    logic [15:0] e5;
    logic [15:0] e10;
    logic [15:0] e11;
    logic        eovf;
    logic        edz;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input vec_t v);
    bus.inv_tan      = v.inv_tan;
    bus.aspect_ratio = v.aspect;
    bus.z_near       = v.z_near;
    bus.z_far        = v.z_far;
  endtask

  task automatic check_result(input vec_t v, input string tag);
    logic [15:0] e;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       e = v.e0;
        5:       e = v.e5;
        10:      e = v.e10;
        11:      e = v.e11;
        14:      e = 16'h0100;
        default: e = 16'h0000;
      endcase
      chk($sformatf("%s m[%0d]", tag, i), 32'(bus.projection_matrix[i]), 32'(e));
    end
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(v.eovf));
    chk({tag, " div_zero"}, 32'(bus.div_zero), 32'(v.edz));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, " div_zero"}, 32'(bus.div_zero), 32'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s m[%0d]", tag, i), 32'(bus.projection_matrix[i]), 32'd0);
  endtask

  // Entered on a negedge; start is raised in the following cycle, which must be IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    set_ops(v);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 32'd52);
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check_result(v, tag);
  endtask

  initial begin
    int n;
    vec_t junk;

    vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0A00, 16'h0100, 16'h0100, 16'hFECC, 16'h0230, 1'b0, 1'b0};
    vecs[1] = '{16'h0100, 16'h0180, 16'h0100, 16'h0A00, 16'h00AB, 16'h0100, 16'hFECC, 16'h0230, 1'b0, 1'b0};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0200, 16'hFF00, 16'h0080, 16'h0200, 16'hFE00, 16'h0200, 16'hFE54, 16'h0156, 1'b0, 1'b0};
    vecs[4] = '{16'h0100, 16'h0100, 16'h0A00, 16'h0100, 16'h0100, 16'h0100, 16'h0134, 16'hFDD0, 1'b0, 1'b0};
    vecs[5] = '{16'hFF00, 16'h0000, 16'h0100, 16'h0A00, 16'h8000, 16'hFF00, 16'hFECC, 16'h0230, 1'b0, 1'b1};
    vecs[6] = '{16'h7F00, 16'h0040, 16'h0100, 16'h0A00, 16'h7FFF, 16'h7F00, 16'hFECC, 16'h0230, 1'b1, 1'b0};
    junk    = '{16'h1234, 16'h0000, 16'h0300, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

    bus.start = 1'b0;
    set_ops(vecs[0]);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rstn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of DIV_K discards the computation and the previous result.
    set_ops(vecs[1]);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_cleared("midreset");
    @(negedge clk) rstn = 1'b1;
    check_cleared("after midreset");
    run_vec(vecs[0], "post-reset");

    // start held high: operands changed while busy must not matter, and the next accept waits out DONE.
    set_ops(vecs[0]);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    chk("held busy", 32'(bus.busy), 32'd1);
    set_ops(junk);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("held first latency", n, 32'd52);
    check_result(vecs[0], "held first");
    set_ops(vecs[1]);
    @(negedge clk);
    chk("held idle busy", 32'(bus.busy), 32'd0);
    chk("held idle done", 32'(bus.done), 32'd0);
    n = 1;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("held period", n, 32'd54);
    check_result(vecs[1], "held second");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
